// File: rtl/div_pipe_stream_if.sv
// Operand/result stream bundle for the pipelined divider.
// master: issue side (drives operands, accepts results); slave: divider.
interface div_pipe_stream_if #(
    parameter int N     = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [TAG_W-1:0] in_tag;
    logic [N-1:0]     dividend;
    logic [N-1:0]     divisor;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic [TAG_W-1:0] out_tag;
    logic             div_zero;
    logic             ovf;

    modport master (
        output in_valid, in_signed, in_tag, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, out_tag,
        input  div_zero, ovf
    );

    modport slave (
        input  in_valid, in_signed, in_tag, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, out_tag,
        output div_zero, ovf
    );
endinterface

// File: rtl/div_pipe_stream.sv
// Fully pipelined restoring divider, one op per cycle, K quotient bits per stage.
// Ports: clk, rst (async, active-high), flush (sync drop of in-flight ops), bus (slave).
module div_pipe_stream #(
    parameter int N     = 32,
    parameter int K     = 1,
    parameter int TAG_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    div_pipe_stream_if.slave bus
);
    localparam int D = N / K;
    localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

    typedef struct packed {
        logic             vld;
        logic             neg_q;
        logic             neg_r;
        logic             dz;
        logic             ov;
        logic [TAG_W-1:0] tag;
        logic [N:0]       rem;
        logic [N-1:0]     quo;
        logic [N-1:0]     den;
    } slot_t;

    // quo starts as the dividend magnitude; its MSBs are consumed
    // into rem while quotient bits shift in from the LSB.
    function automatic slot_t step(input slot_t s);
        slot_t      r;
        logic [N:0] sh;
        r = s;
        for (int k = 0; k < K; k++) begin
            sh    = {r.rem[N-1:0], r.quo[N-1]};
            r.quo = {r.quo[N-2:0], 1'b0};
            if (sh >= {1'b0, r.den}) begin
                sh       = sh - {1'b0, r.den};
                r.quo[0] = 1'b1;
            end
            r.rem = sh;
        end
        return r;
    endfunction

    slot_t        pipe [0:D];
    slot_t        nxt  [1:D];
    slot_t        s0_in;
    logic         adv;
    logic [N-1:0] q_mag;
    logic [N-1:0] r_mag;
    logic [N-1:0] fin_q;
    logic [N-1:0] fin_r;
    logic         unused_bits;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        s0_in       = '0;
        s0_in.vld   = bus.in_valid;
        s0_in.neg_q = bus.in_signed && (bus.dividend[N-1] ^ bus.divisor[N-1]);
        s0_in.neg_r = bus.in_signed && bus.dividend[N-1];
        s0_in.dz    = (bus.divisor == '0);
        s0_in.ov    = bus.in_signed && (bus.dividend == MIN)
                      && (bus.divisor == '1);
        s0_in.tag   = bus.in_tag;
        s0_in.quo   = (bus.in_signed && bus.dividend[N-1]) ? -bus.dividend
                                                           : bus.dividend;
        s0_in.den   = (bus.in_signed && bus.divisor[N-1]) ? -bus.divisor
                                                          : bus.divisor;
    end

    always_comb begin
        for (int i = 1; i <= D; i++) begin
            nxt[i] = step(pipe[i-1]);
        end
    end

    // A zero divisor leaves rem equal to the dividend magnitude, so the
    // normal sign fix-up already returns the raw dividend as remainder.
    always_comb begin
        q_mag = pipe[D].quo;
        r_mag = pipe[D].rem[N-1:0];
        fin_q = pipe[D].neg_q ? -q_mag : q_mag;
        fin_r = pipe[D].neg_r ? -r_mag : r_mag;
        if (pipe[D].dz) begin
            fin_q = '1;
        end else if (pipe[D].ov) begin
            fin_q = MIN;
            fin_r = '0;
        end
    end

    assign unused_bits = ^{pipe[D].rem[N], pipe[D].den};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= D; i++) begin
                pipe[i] <= '0;
            end
            bus.out_valid <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.out_tag   <= '0;
            bus.div_zero  <= 1'b0;
            bus.ovf       <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i <= D; i++) begin
                pipe[i].vld <= 1'b0;
            end
            bus.out_valid <= 1'b0;
        end else if (adv) begin
            pipe[0] <= s0_in;
            for (int i = 1; i <= D; i++) begin
                pipe[i] <= nxt[i];
            end
            bus.out_valid <= pipe[D].vld;
            bus.quotient  <= fin_q;
            bus.remainder <= fin_r;
            bus.out_tag   <= pipe[D].tag;
            bus.div_zero  <= pipe[D].dz;
            bus.ovf       <= pipe[D].ov && !pipe[D].dz;
        end
    end
endmodule
